// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, debug and memory port bundle for imem_arbiter
// slave is the arbiter's view; master is the view of the surrounding masters and memory.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-master arbiter for the single-port instruction memory
// Round-robin between fetch and debug, with debug burst lock and a fetch starvation guard.
module imem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus,
  output logic          hold_o
);
  localparam int unsigned       WAIT_W    = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  owner_e              last_owner_q, last_owner_d;
  logic                locked_q, locked_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                dbg_err_q, dbg_err_d;

  logic                gnt_if;
  logic                gnt_dbg;
  logic                dbg_aligned;

  assign dbg_aligned = (bus.dbg_addr[1:0] == 2'b00);

  // Starvation guard outranks the debug lock so a burst can never hold fetch off indefinitely.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_dbg = 1'b0;
    if (rst) begin
      if (bus.if_req && (wait_q == WAIT_MAX)) begin
        gnt_if = 1'b1;
      end else if (bus.dbg_req && locked_q) begin
        gnt_dbg = 1'b1;
      end else if (bus.if_req && bus.dbg_req) begin
        if (last_owner_q == OWNER_DBG) begin
          gnt_if = 1'b1;
        end else begin
          gnt_dbg = 1'b1;
        end
      end else if (bus.if_req) begin
        gnt_if = 1'b1;
      end else if (bus.dbg_req) begin
        gnt_dbg = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_if) begin
      bus.mem_addr = bus.if_addr & WORD_MASK;
    end else if (gnt_dbg) begin
      bus.mem_addr  = bus.dbg_addr & WORD_MASK;
      bus.mem_rw    = bus.dbg_we & dbg_aligned;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  // A dropped misaligned write still updates last_owner, so it costs debug its turn.
  always_comb begin
    last_owner_d = last_owner_q;
    locked_d     = 1'b0;
    wait_d       = wait_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_err_d    = 1'b0;

    if (gnt_if) begin
      last_owner_d = OWNER_IF;
      if_rvalid_d  = 1'b1;
      if_rdata_d   = bus.mem_rdata;
    end

    if (gnt_dbg) begin
      last_owner_d = OWNER_DBG;
      locked_d     = bus.dbg_lock;
      if (bus.dbg_we) begin
        dbg_err_d = ~dbg_aligned;
      end else begin
        dbg_rvalid_d = 1'b1;
        dbg_rdata_d  = bus.mem_rdata;
      end
    end

    if (gnt_if || !bus.if_req) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner_q <= OWNER_DBG;
      locked_q     <= 1'b0;
      wait_q       <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      locked_q     <= locked_d;
      wait_q       <= wait_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  assign bus.if_gnt     = gnt_if;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.dbg_gnt    = gnt_dbg;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_err    = dbg_err_q;
  assign hold_o         = bus.if_req & ~gnt_if;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed table plus randomized check of imem_arbiter
// Reference model derives arbitration from a per-cycle grant history.
module tb_imem_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst;
  logic hold_o;

  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .hold_o (hold_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Memory environment: 64 words, combinational read, write on the clock edge.
  logic [31:0] env_mem [64];
  assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
    end else if (bus.mem_rw) begin
      env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  int n_err;
  int n_checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: history of cycles since reset plus a word-level memory copy.
  typedef struct {
    bit if_req;
    bit gif;
    bit gdbg;
    bit lock;
  } hist_t;

  hist_t       hist[$];
  int          owners[$];
  logic [31:0] ref_mem [64];
  logic        exp_if_rv, exp_dbg_rv, exp_err;
  logic [31:0] exp_if_rd, exp_dbg_rd;

  task automatic model_reset();
    hist.delete();
    owners.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    exp_if_rv  = 1'b0;
    exp_dbg_rv = 1'b0;
    exp_err    = 1'b0;
    exp_if_rd  = '0;
    exp_dbg_rd = '0;
  endtask

  function automatic int starve_run();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].if_req && !hist[i].gif) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_step(input string tag);
    bit          w_if, w_dbg, locked, last_dbg, aligned;
    int          iidx, didx;
    logic [31:0] exp_addr;
    w_if     = 1'b0;
    w_dbg    = 1'b0;
    locked   = (hist.size() > 0) && hist[hist.size()-1].gdbg && hist[hist.size()-1].lock;
    last_dbg = (owners.size() == 0) || (owners[owners.size()-1] == 1);
    aligned  = (bus.dbg_addr[1:0] == 2'b00);
    iidx     = int'(bus.if_addr[7:2]);
    didx     = int'(bus.dbg_addr[7:2]);
    if (rst) begin
      if (bus.if_req && starve_run() >= MAX_WAIT) w_if = 1'b1;
      else if (bus.dbg_req && locked) w_dbg = 1'b1;
      else if (bus.if_req && bus.dbg_req) begin
        if (last_dbg) w_if = 1'b1;
        else w_dbg = 1'b1;
      end
      else if (bus.if_req) w_if = 1'b1;
      else if (bus.dbg_req) w_dbg = 1'b1;
    end
    exp_addr = w_if ? {bus.if_addr[31:2], 2'b00} : (w_dbg ? {bus.dbg_addr[31:2], 2'b00} : 32'h0);

    chk({tag, ".if_gnt"}, bus.if_gnt, w_if);
    chk({tag, ".dbg_gnt"}, bus.dbg_gnt, w_dbg);
    chk({tag, ".hold_o"}, hold_o, bus.if_req & ~w_if);
    chk({tag, ".mem_rw"}, bus.mem_rw, w_dbg & bus.dbg_we & aligned);
    chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
    if (!w_if) chk({tag, ".mem_wdata"}, bus.mem_wdata, w_dbg ? bus.dbg_wdata : 32'h0);
    chk({tag, ".if_rvalid"}, bus.if_rvalid, exp_if_rv);
    chk({tag, ".dbg_rvalid"}, bus.dbg_rvalid, exp_dbg_rv);
    chk({tag, ".dbg_err"}, bus.dbg_err, exp_err);
    chk({tag, ".if_rdata"}, bus.if_rdata, exp_if_rd);
    chk({tag, ".dbg_rdata"}, bus.dbg_rdata, exp_dbg_rd);

    if (!rst) begin
      model_reset();
    end else begin
      hist.push_back('{if_req: bus.if_req, gif: w_if, gdbg: w_dbg, lock: bus.dbg_lock});
      if (hist.size() > 16) void'(hist.pop_front());
      if (w_if) owners.push_back(0);
      if (w_dbg) owners.push_back(1);
      if (owners.size() > 4) void'(owners.pop_front());
      exp_if_rv  = w_if;
      exp_dbg_rv = w_dbg && !bus.dbg_we;
      exp_err    = w_dbg && bus.dbg_we && !aligned;
      if (w_if) exp_if_rd = ref_mem[iidx];
      if (w_dbg && !bus.dbg_we) exp_dbg_rd = ref_mem[didx];
      if (w_dbg && bus.dbg_we && aligned) ref_mem[didx] = bus.dbg_wdata;
    end
  endtask

  // exp bits: {if_gnt, dbg_gnt, mem_rw, hold_o, if_rvalid, dbg_rvalid, dbg_err}
  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic        dl;
    logic [31:0] da;
    logic [31:0] dd;
    logic [6:0]  exp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t v(input logic r, input logic ir, input logic [31:0] ia,
                             input logic dr, input logic dw, input logic dl,
                             input logic [31:0] da, input logic [31:0] dd,
                             input logic [6:0] e, input logic c, input logic [31:0] rd);
    vec_t t;
    t.rst = r; t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw; t.dl = dl;
    t.da = da; t.dd = dd; t.exp = e; t.chk_rd = c; t.exp_rd = rd;
    return t;
  endfunction

  vec_t vecs[30];

  initial begin
    n_err = 0;
    n_checks = 0;

    vecs[0]  = v(0, 1, 32'h00, 1, 0, 1, 32'h20, 32'h0,        7'b0001000, 0, 32'h0);
    vecs[1]  = v(0, 1, 32'h00, 1, 0, 1, 32'h20, 32'h0,        7'b0001000, 0, 32'h0);
    vecs[2]  = v(1, 1, 32'h00, 1, 0, 0, 32'h20, 32'h0,        7'b1000000, 0, 32'h0);
    vecs[3]  = v(1, 1, 32'h04, 0, 0, 0, 32'h20, 32'h0,        7'b1000100, 0, 32'h0);
    vecs[4]  = v(1, 1, 32'h08, 0, 0, 0, 32'h20, 32'h0,        7'b1000100, 0, 32'h0);
    vecs[5]  = v(1, 0, 32'h08, 1, 0, 0, 32'h24, 32'h0,        7'b0100100, 0, 32'h0);
    vecs[6]  = v(1, 1, 32'h0C, 1, 0, 0, 32'h20, 32'h0,        7'b1000010, 1, 32'h1000_0009);
    vecs[7]  = v(1, 1, 32'h0C, 1, 0, 0, 32'h20, 32'h0,        7'b0101100, 0, 32'h0);
    vecs[8]  = v(1, 1, 32'h0C, 1, 0, 0, 32'h20, 32'h0,        7'b1000010, 0, 32'h0);
    vecs[9]  = v(1, 1, 32'h0C, 1, 0, 0, 32'h20, 32'h0,        7'b0101100, 0, 32'h0);
    vecs[10] = v(1, 1, 32'h0C, 1, 0, 0, 32'h20, 32'h0,        7'b1000010, 0, 32'h0);
    vecs[11] = v(1, 1, 32'h0C, 1, 0, 0, 32'h20, 32'h0,        7'b0101100, 0, 32'h0);
    vecs[12] = v(1, 0, 32'h00, 1, 1, 0, 32'h10, 32'hDEADBEEF, 7'b0110010, 0, 32'h0);
    vecs[13] = v(1, 0, 32'h00, 1, 0, 0, 32'h10, 32'h0,        7'b0100000, 0, 32'h0);
    vecs[14] = v(1, 0, 32'h00, 0, 0, 0, 32'h10, 32'h0,        7'b0000010, 1, 32'hDEADBEEF);
    vecs[15] = v(1, 0, 32'h40, 1, 0, 1, 32'h28, 32'h0,        7'b0100000, 0, 32'h0);
    vecs[16] = v(1, 1, 32'h40, 1, 0, 1, 32'h28, 32'h0,        7'b0101010, 0, 32'h0);
    vecs[17] = v(1, 1, 32'h40, 1, 0, 1, 32'h28, 32'h0,        7'b0101010, 0, 32'h0);
    vecs[18] = v(1, 1, 32'h40, 1, 0, 1, 32'h28, 32'h0,        7'b0101010, 0, 32'h0);
    vecs[19] = v(1, 1, 32'h40, 1, 0, 1, 32'h28, 32'h0,        7'b0101010, 0, 32'h0);
    vecs[20] = v(1, 1, 32'h40, 1, 0, 1, 32'h28, 32'h0,        7'b1000010, 0, 32'h0);
    vecs[21] = v(1, 1, 32'h40, 1, 0, 0, 32'h28, 32'h0,        7'b0101100, 0, 32'h0);
    vecs[22] = v(1, 1, 32'h40, 1, 0, 0, 32'h28, 32'h0,        7'b1000010, 0, 32'h0);
    vecs[23] = v(1, 0, 32'h00, 1, 1, 0, 32'h13, 32'h55AA55AA, 7'b0100100, 0, 32'h0);
    vecs[24] = v(1, 0, 32'h00, 1, 0, 0, 32'h10, 32'h0,        7'b0100001, 0, 32'h0);
    vecs[25] = v(1, 0, 32'h00, 0, 0, 0, 32'h10, 32'h0,        7'b0000010, 1, 32'hDEADBEEF);
    vecs[26] = v(1, 0, 32'h00, 1, 1, 1, 32'h30, 32'h12345678, 7'b0110000, 0, 32'h0);
    vecs[27] = v(0, 1, 32'h30, 1, 0, 1, 32'h30, 32'h0,        7'b0001000, 0, 32'h0);
    vecs[28] = v(1, 1, 32'h30, 1, 0, 1, 32'h30, 32'h0,        7'b1000000, 0, 32'h0);
    vecs[29] = v(1, 1, 32'h30, 1, 0, 1, 32'h30, 32'h0,        7'b0101100, 0, 32'h0);

    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b0;
    bus.dbg_addr = '0; bus.dbg_wdata = '0;
    @(posedge clk); #1;
    model_reset();

    for (int i = 0; i < 30; i++) begin
      rst           = vecs[i].rst;
      bus.if_req    = vecs[i].ir;
      bus.if_addr   = vecs[i].ia;
      bus.dbg_req   = vecs[i].dr;
      bus.dbg_we    = vecs[i].dw;
      bus.dbg_lock  = vecs[i].dl;
      bus.dbg_addr  = vecs[i].da;
      bus.dbg_wdata = vecs[i].dd;
      @(negedge clk);
      chk($sformatf("vec%0d.if_gnt", i),     bus.if_gnt,     vecs[i].exp[6]);
      chk($sformatf("vec%0d.dbg_gnt", i),    bus.dbg_gnt,    vecs[i].exp[5]);
      chk($sformatf("vec%0d.mem_rw", i),     bus.mem_rw,     vecs[i].exp[4]);
      chk($sformatf("vec%0d.hold_o", i),     hold_o,         vecs[i].exp[3]);
      chk($sformatf("vec%0d.if_rvalid", i),  bus.if_rvalid,  vecs[i].exp[2]);
      chk($sformatf("vec%0d.dbg_rvalid", i), bus.dbg_rvalid, vecs[i].exp[1]);
      chk($sformatf("vec%0d.dbg_err", i),    bus.dbg_err,    vecs[i].exp[0]);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d.dbg_rdata", i), bus.dbg_rdata, vecs[i].exp_rd);
      model_step($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    for (int c = 0; c < 800; c++) begin
      rst           = ($urandom_range(0, 49) != 0);
      bus.if_req    = ($urandom_range(0, 9) < 7);
      bus.if_addr   = $urandom();
      bus.dbg_req   = ($urandom_range(0, 9) < 6);
      bus.dbg_we    = ($urandom_range(0, 9) < 3);
      bus.dbg_lock  = ($urandom_range(0, 9) < 5);
      bus.dbg_addr  = ($urandom() & 32'hFFFF_FFFC) |
                      (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      bus.dbg_wdata = $urandom();
      @(negedge clk);
      model_step($sformatf("rnd%0d", c));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
